// File: rtl/amdc_sensor_done_tracker_if.sv
// amdc_sensor_done_tracker_if
//   Bundles the trigger, per-sensor done/enable lines, flag clears and all
//   status outputs of the sensor done tracker.
//   master : scheduler / timing-manager side (drives trigger, masks, limits)
//   slave  : the tracker itself
// Optional statistics ports (max_time, period_cnt) exist only when
// SENSOR_DONE_TRACKER_STATS_EN is defined.
interface amdc_sensor_done_tracker_if #(
    parameter int unsigned NUM_SENSORS = 8,
    parameter int unsigned TIME_W      = 16
) ();
    logic                          trigger;
    logic [NUM_SENSORS-1:0]        sensor_en;
    logic [NUM_SENSORS-1:0]        sensor_done;
    logic [TIME_W-1:0]             timeout_cyc;
    logic                          clr_flags;
    logic                          busy;
    logic                          all_done;
    logic                          timeout_err;
    logic                          timeout_sticky;
    logic                          overrun;
    logic [NUM_SENSORS-1:0]        done_mask;
    logic [NUM_SENSORS*TIME_W-1:0] acq_time;
    logic [TIME_W-1:0]             total_time;
`ifdef SENSOR_DONE_TRACKER_STATS_EN
    logic [TIME_W-1:0]             max_time;
    logic [31:0]                   period_cnt;
`endif

    modport master (
`ifdef SENSOR_DONE_TRACKER_STATS_EN
        input  max_time, period_cnt,
`endif
        output trigger, sensor_en, sensor_done, timeout_cyc, clr_flags,
        input  busy, all_done, timeout_err, timeout_sticky, overrun,
        input  done_mask, acq_time, total_time
    );

    modport slave (
`ifdef SENSOR_DONE_TRACKER_STATS_EN
        output max_time, period_cnt,
`endif
        input  trigger, sensor_en, sensor_done, timeout_cyc, clr_flags,
        output busy, all_done, timeout_err, timeout_sticky, overrun,
        output done_mask, acq_time, total_time
    );
endinterface

// File: rtl/amdc_sensor_done_tracker.sv
// amdc_sensor_done_tracker
//   Consumes the per-period trigger from the timing manager, collects the
//   per-sensor done pulses, latches each sensor's acquisition time in ACLK
//   cycles and reports completion, timeout and overrun to the scheduler ISR.
// Ports
//   ACLK   : clock, all logic on the rising edge
//   ARESET : synchronous, active-high reset
//   bus    : amdc_sensor_done_tracker_if.slave
//            in : trigger, sensor_en, sensor_done, timeout_cyc, clr_flags
//            out: busy, all_done, timeout_err, timeout_sticky, overrun,
//                 done_mask, acq_time (slice i = [i*TIME_W +: TIME_W]),
//                 total_time
// Configuration
//   SENSOR_DONE_TRACKER_STATS_EN : adds max_time / period_cnt statistics.
module amdc_sensor_done_tracker #(
    parameter int unsigned NUM_SENSORS = 8,
    parameter int unsigned TIME_W      = 16
) (
    input logic                       ACLK,
    input logic                       ARESET,
    amdc_sensor_done_tracker_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, ACQ = 1'b1} state_t;

    state_t                        state, state_d;
    logic [TIME_W-1:0]             cnt;
    logic [NUM_SENSORS-1:0]        en_q;
    logic [NUM_SENSORS-1:0]        done_mask_q;
    logic [NUM_SENSORS*TIME_W-1:0] acq_time_q;
    logic [TIME_W-1:0]             total_time_q;
    logic                          busy_q, all_done_q, timeout_err_q;
    logic                          timeout_sticky_q, overrun_q;

    logic [NUM_SENSORS-1:0]        new_done_c;
    logic                          start_c, empty_start_c;
    logic                          complete_c, timeout_c, overrun_set_c;

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= state_d;
    end

    // Next state and period events
    always_comb begin
        state_d       = state;
        start_c       = 1'b0;
        empty_start_c = 1'b0;
        complete_c    = 1'b0;
        timeout_c     = 1'b0;
        overrun_set_c = 1'b0;
        new_done_c    = '0;
        case (state)
            IDLE: begin
                if (bus.trigger) begin
                    if (|bus.sensor_en) begin
                        start_c = 1'b1;
                        state_d = ACQ;
                    end else begin
                        empty_start_c = 1'b1;
                    end
                end
            end
            ACQ: begin
                // first pulse of an enabled sensor only
                new_done_c    = bus.sensor_done & en_q & ~done_mask_q;
                complete_c    = &(done_mask_q | new_done_c | ~en_q);
                // completion on the same cycle takes priority over timeout
                timeout_c     = !complete_c && (bus.timeout_cyc != '0) &&
                                (cnt == bus.timeout_cyc);
                overrun_set_c = bus.trigger;
                if (complete_c || timeout_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Period datapath: counter, masks, per-sensor and total times
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt          <= '0;
            en_q         <= '0;
            done_mask_q  <= '0;
            acq_time_q   <= '0;
            total_time_q <= '0;
        end else begin
            if (start_c) begin
                en_q        <= bus.sensor_en;
                done_mask_q <= '0;
                acq_time_q  <= '0;
                cnt         <= TIME_W'(1);
            end else if (state == ACQ) begin
                if (cnt != '1) cnt <= cnt + TIME_W'(1);
                done_mask_q <= done_mask_q | new_done_c;
                for (int i = 0; i < int'(NUM_SENSORS); i++) begin
                    if (new_done_c[i]) acq_time_q[i*TIME_W +: TIME_W] <= cnt;
                end
            end
            if (complete_c || timeout_c) total_time_q <= cnt;
            else if (empty_start_c)      total_time_q <= '0;
        end
    end

    // Pulses, busy and sticky flags; a set event beats a same-cycle clear
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            busy_q           <= 1'b0;
            all_done_q       <= 1'b0;
            timeout_err_q    <= 1'b0;
            timeout_sticky_q <= 1'b0;
            overrun_q        <= 1'b0;
        end else begin
            busy_q        <= (state_d == ACQ);
            all_done_q    <= complete_c || empty_start_c;
            timeout_err_q <= timeout_c;
            if (timeout_c)          timeout_sticky_q <= 1'b1;
            else if (bus.clr_flags) timeout_sticky_q <= 1'b0;
            if (overrun_set_c)      overrun_q <= 1'b1;
            else if (bus.clr_flags) overrun_q <= 1'b0;
        end
    end

`ifdef SENSOR_DONE_TRACKER_STATS_EN
    logic [TIME_W-1:0] max_time_q;
    logic [31:0]       period_cnt_q;
    logic              period_end_c;
    logic [TIME_W-1:0] period_time_c;

    assign period_end_c  = complete_c || empty_start_c;
    assign period_time_c = complete_c ? cnt : '0;

    // Completed-period statistics; a same-cycle clear restarts from this period
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            max_time_q   <= '0;
            period_cnt_q <= '0;
        end else if (bus.clr_flags) begin
            max_time_q   <= period_end_c ? period_time_c : '0;
            period_cnt_q <= period_end_c ? 32'd1 : 32'd0;
        end else if (period_end_c) begin
            if (period_time_c > max_time_q) max_time_q <= period_time_c;
            period_cnt_q <= period_cnt_q + 32'd1;
        end
    end

    assign bus.max_time   = max_time_q;
    assign bus.period_cnt = period_cnt_q;
`endif

    assign bus.busy           = busy_q;
    assign bus.all_done       = all_done_q;
    assign bus.timeout_err    = timeout_err_q;
    assign bus.timeout_sticky = timeout_sticky_q;
    assign bus.overrun        = overrun_q;
    assign bus.done_mask      = done_mask_q;
    assign bus.acq_time       = acq_time_q;
    assign bus.total_time     = total_time_q;
endmodule

// File: tb/tb_amdc_sensor_done_tracker.sv
// Testbench for amdc_sensor_done_tracker: table of directed periods, hand
// sequences for overrun/reset/back-to-back corners, then randomized periods
// checked against a period-level reference model.
module tb_amdc_sensor_done_tracker;
    localparam int unsigned NS = 8;
    localparam int unsigned TW = 16;

    logic ACLK = 1'b0;
    logic ARESET;
    always #5 ACLK = ~ACLK;

    amdc_sensor_done_tracker_if #(.NUM_SENSORS(NS), .TIME_W(TW)) bus ();
    amdc_sensor_done_tracker #(.NUM_SENSORS(NS), .TIME_W(TW)) dut (
        .ACLK  (ACLK),
        .ARESET(ARESET),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // last done_mask/acq_time the model believes the DUT holds
    logic [NS-1:0]    m_mask = '0;
    logic [NS*TW-1:0] m_acq  = '0;

    typedef struct {
        logic [7:0]           en;
        logic [NS-1:0][7:0]   at;
        logic [15:0]          to;
        int                   exp_end;
        bit                   exp_done;
        logic [7:0]           exp_mask;
        logic [15:0]          exp_total;
        logic [127:0]         exp_acq;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // Trigger one period, replay done pulses at their cycle numbers, watch for the end
    task automatic run_period(input logic [7:0] en, input logic [NS-1:0][7:0] at,
                              input logic [15:0] to, input bit noise,
                              output int end_c, output bit got_done, output bit got_to);
        logic [NS-1:0] d;
        logic [NS-1:0] dup;
        end_c    = -1;
        got_done = 1'b0;
        got_to   = 1'b0;
        bus.sensor_en   = en;
        bus.timeout_cyc = to;
        bus.sensor_done = '0;
        bus.trigger     = 1'b1;
        step();
        bus.trigger = 1'b0;
        if (bus.all_done || bus.timeout_err) begin
            end_c = 0; got_done = bus.all_done; got_to = bus.timeout_err;
        end
        for (int c = 1; c <= 200 && end_c < 0; c++) begin
            d   = '0;
            dup = '0;
            for (int i = 0; i < int'(NS); i++) begin
                if (int'(at[i]) == c) d[i] = 1'b1;
                if (at[i] != 0 && int'(at[i]) < c) dup[i] = 1'b1;
            end
            if (noise) d = d | (NS'($urandom) & (~en | dup));
            bus.sensor_done = d;
            step();
            if (bus.all_done || bus.timeout_err) begin
                end_c = c; got_done = bus.all_done; got_to = bus.timeout_err;
            end
        end
        bus.sensor_done = '0;
    endtask

    task automatic compare_outcome(input string nm, input int e_end, input bit e_done,
                                   input logic [7:0] e_mask, input logic [15:0] e_total,
                                   input logic [127:0] e_acq,
                                   input int end_c, input bit gd, input bit gt);
        check({nm, ".end_cycle"}, 128'(end_c), 128'(e_end));
        check({nm, ".all_done"}, 128'(gd), 128'(e_done));
        check({nm, ".timeout_err"}, 128'(gt), 128'(!e_done));
        check({nm, ".total_time"}, 128'(bus.total_time), 128'(e_total));
        check({nm, ".done_mask"}, 128'(bus.done_mask), 128'(e_mask));
        check({nm, ".acq_time"}, 128'(bus.acq_time), e_acq);
        check({nm, ".busy"}, 128'(bus.busy), 128'(0));
        if (!e_done) check({nm, ".timeout_sticky"}, 128'(bus.timeout_sticky), 128'(1));
    endtask

    // Period-level reference: the period ends at the last enabled sensor's
    // first pulse unless the timeout limit is reached strictly earlier.
    task automatic model_check(input string nm, input logic [7:0] en,
                               input logic [NS-1:0][7:0] at, input logic [15:0] to,
                               input int end_c, input bit gd, input bit gt);
        int comp;
        bit missing;
        int e_end;
        bit e_done;
        logic [7:0] e_mask;
        logic [127:0] e_acq;
        comp = 0;
        missing = 1'b0;
        for (int i = 0; i < int'(NS); i++) begin
            if (en[i]) begin
                if (at[i] == 0) missing = 1'b1;
                else if (int'(at[i]) > comp) comp = int'(at[i]);
            end
        end
        if (en == 0) begin
            e_end = 0; e_done = 1'b1; e_mask = m_mask; e_acq = 128'(m_acq);
        end else begin
            if (!missing && (to == 0 || comp <= int'(to))) begin
                e_end = comp; e_done = 1'b1;
            end else begin
                e_end = int'(to); e_done = 1'b0;
            end
            e_mask = '0;
            e_acq  = '0;
            for (int i = 0; i < int'(NS); i++) begin
                if (en[i] && at[i] != 0 && int'(at[i]) <= e_end) begin
                    e_mask[i] = 1'b1;
                    e_acq[i*16 +: 16] = 16'(at[i]);
                end
            end
            m_mask = e_mask;
            m_acq  = (NS*TW)'(e_acq);
        end
        compare_outcome(nm, e_end, e_done, e_mask, 16'(e_end), e_acq, end_c, gd, gt);
    endtask

    initial begin
        int end_c;
        bit gd, gt;
        logic [NS-1:0][7:0] at;
        logic [7:0] ren;
        logic [15:0] rto;

        vecs[0] = '{8'h05, 64'h00000000_00070003, 16'd0,  7, 1'b1, 8'h05, 16'd7,  128'h0007_0000_0003};
        vecs[1] = '{8'h03, 64'h00000000_00000004, 16'd10, 10, 1'b0, 8'h01, 16'd10, 128'h4};
        vecs[2] = '{8'h00, 64'h0,                 16'd0,  0, 1'b1, 8'h01, 16'd0,  128'h4};
        vecs[3] = '{8'h01, 64'h00000000_00000001, 16'd0,  1, 1'b1, 8'h01, 16'd1,  128'h1};
        vecs[4] = '{8'h81, 64'h05000000_00000005, 16'd5,  5, 1'b1, 8'h81, 16'd5,
                    128'h0005_0000_0000_0000_0000_0000_0000_0005};
        vecs[5] = '{8'h0F, 64'h00000000_04030201, 16'd3,  3, 1'b0, 8'h07, 16'd3,  128'h0003_0002_0001};

        bus.trigger = 1'b0; bus.sensor_en = '0; bus.sensor_done = '0;
        bus.timeout_cyc = '0; bus.clr_flags = 1'b0;
        ARESET = 1'b1;
        repeat (3) step();
        ARESET = 1'b0;
        check("rst.busy", 128'(bus.busy), 128'(0));
        check("rst.all_done", 128'(bus.all_done), 128'(0));
        check("rst.flags", 128'({bus.timeout_err, bus.timeout_sticky, bus.overrun}), 128'(0));
        check("rst.done_mask", 128'(bus.done_mask), 128'(0));
        check("rst.acq_time", 128'(bus.acq_time), 128'(0));
        check("rst.total_time", 128'(bus.total_time), 128'(0));
        step();

        for (int v = 0; v < 6; v++) begin
            run_period(vecs[v].en, vecs[v].at, vecs[v].to, 1'b0, end_c, gd, gt);
            compare_outcome($sformatf("vec%0d", v), vecs[v].exp_end, vecs[v].exp_done,
                            vecs[v].exp_mask, vecs[v].exp_total, vecs[v].exp_acq, end_c, gd, gt);
            step();
        end

        // Trigger mid-period sets overrun but does not restart the period
        bus.sensor_en = 8'h03; bus.timeout_cyc = '0; bus.trigger = 1'b1;
        step();
        for (int c = 1; c <= 8; c++) begin
            bus.trigger = (c == 5);
            bus.sensor_done = (c == 6) ? 8'h01 : (c == 8) ? 8'h02 : 8'h00;
            step();
            if (c == 5) begin
                check("ovr.overrun_set", 128'(bus.overrun), 128'(1));
                check("ovr.busy", 128'(bus.busy), 128'(1));
            end
            if (c == 7) check("ovr.no_early_done", 128'(bus.all_done), 128'(0));
        end
        bus.trigger = 1'b0; bus.sensor_done = '0;
        check("ovr.all_done", 128'(bus.all_done), 128'(1));
        check("ovr.total_time", 128'(bus.total_time), 128'(8));
        check("ovr.acq_time", 128'(bus.acq_time), 128'h0008_0006);
        bus.clr_flags = 1'b1;
        step();
        bus.clr_flags = 1'b0;
        check("clr.overrun", 128'(bus.overrun), 128'(0));
        check("clr.timeout_sticky", 128'(bus.timeout_sticky), 128'(0));
        check("clr.all_done_single", 128'(bus.all_done), 128'(0));

        // Empty period, then a trigger on the all_done cycle is accepted
        bus.sensor_en = 8'h00; bus.trigger = 1'b1;
        step();
        check("b2b.empty_done", 128'(bus.all_done), 128'(1));
        check("b2b.empty_busy", 128'(bus.busy), 128'(0));
        check("b2b.empty_total", 128'(bus.total_time), 128'(0));
        bus.sensor_en = 8'h01;
        step();
        bus.trigger = 1'b0;
        check("b2b.busy", 128'(bus.busy), 128'(1));
        check("b2b.no_done", 128'(bus.all_done), 128'(0));
        bus.sensor_done = 8'h01;
        step();
        bus.sensor_done = '0;
        check("b2b.all_done", 128'(bus.all_done), 128'(1));
        check("b2b.total", 128'(bus.total_time), 128'(1));
        check("b2b.overrun", 128'(bus.overrun), 128'(0));
        step();

`ifdef SENSOR_DONE_TRACKER_STATS_EN
        bus.clr_flags = 1'b1;
        step();
        bus.clr_flags = 1'b0;
        check("stats.cleared0", 128'({bus.max_time, bus.period_cnt}), 128'(0));
        for (int k = 0; k < 3; k++) begin
            at = '0;
            at[0] = (k == 0) ? 8'd7 : (k == 1) ? 8'd12 : 8'd9;
            run_period(8'h01, at, 16'd0, 1'b0, end_c, gd, gt);
            check($sformatf("stats.total%0d", k), 128'(bus.total_time), 128'(at[0]));
            step();
        end
        check("stats.max_time", 128'(bus.max_time), 128'(12));
        check("stats.period_cnt", 128'(bus.period_cnt), 128'(3));
        at = '0;
        at[0] = 8'd1;
        run_period(8'h03, at, 16'd20, 1'b0, end_c, gd, gt);
        check("stats.to_kind", 128'(gt), 128'(1));
        check("stats.to_max", 128'(bus.max_time), 128'(12));
        check("stats.to_cnt", 128'(bus.period_cnt), 128'(3));
        bus.clr_flags = 1'b1;
        step();
        bus.clr_flags = 1'b0;
        check("stats.clr_max", 128'(bus.max_time), 128'(0));
        check("stats.clr_cnt", 128'(bus.period_cnt), 128'(0));
`endif

        // Ignored pulses, clear losing to a same-cycle overrun, then reset mid-period
        bus.sensor_en = 8'h05; bus.timeout_cyc = 16'd0; bus.trigger = 1'b1;
        step();
        for (int c = 1; c <= 5; c++) begin
            bus.sensor_done = (c == 2) ? 8'h01 : (c == 4) ? 8'h03 : 8'h00;
            bus.trigger = (c == 3);
            bus.clr_flags = (c == 3);
            step();
            if (c == 3) check("ign.overrun_set_wins", 128'(bus.overrun), 128'(1));
        end
        bus.sensor_done = '0; bus.trigger = 1'b0; bus.clr_flags = 1'b0;
        check("ign.acq_time", 128'(bus.acq_time), 128'h2);
        check("ign.done_mask", 128'(bus.done_mask), 128'h01);
        check("ign.busy", 128'(bus.busy), 128'(1));
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        check("arst.busy", 128'(bus.busy), 128'(0));
        check("arst.pulses", 128'({bus.all_done, bus.timeout_err}), 128'(0));
        check("arst.flags", 128'({bus.timeout_sticky, bus.overrun}), 128'(0));
        check("arst.done_mask", 128'(bus.done_mask), 128'(0));
        check("arst.acq_time", 128'(bus.acq_time), 128'(0));
        check("arst.total_time", 128'(bus.total_time), 128'(0));
        step();
        check("arst.no_pulse", 128'({bus.all_done, bus.timeout_err, bus.busy}), 128'(0));
        m_mask = '0;
        m_acq  = '0;

        // Randomized periods against the reference model
        for (int n = 0; n < 80; n++) begin
            ren = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            rto = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 35));
            for (int i = 0; i < int'(NS); i++) begin
                at[i] = ($urandom_range(0, 5) == 0 && rto != 0) ? 8'd0 : 8'($urandom_range(1, 30));
            end
            run_period(ren, at, rto, 1'b1, end_c, gd, gt);
            model_check($sformatf("rnd%0d", n), ren, at, rto, end_c, gd, gt);
            repeat ($urandom_range(0, 2)) step();
        end
        check("rnd.no_overrun", 128'(bus.overrun), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
